// File: rtl/exe_pkg.sv
// Shared ALU opcode constants and multiplier FSM state type for the EXE stage.
package exe_pkg;

    localparam logic [3:0] ALUC_ADD = 4'd0;
    localparam logic [3:0] ALUC_SUB = 4'd1;
    localparam logic [3:0] ALUC_AND = 4'd2;
    localparam logic [3:0] ALUC_OR  = 4'd3;
    localparam logic [3:0] ALUC_XOR = 4'd4;
    localparam logic [3:0] ALUC_NOR = 4'd5;
    localparam logic [3:0] ALUC_SLT = 4'd6;
    localparam logic [3:0] ALUC_SLL = 4'd7;
    localparam logic [3:0] ALUC_SRL = 4'd8;
    localparam logic [3:0] ALUC_SRA = 4'd9;
    localparam logic [3:0] ALUC_LUI = 4'd10;
    localparam logic [3:0] ALUC_MUL = 4'd11;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/exe_alu.sv
// Combinational single-cycle ALU for the EXE stage; MUL is produced by the
// sequential multiplier in exe_stage, so this block returns 0 for it.
module exe_alu
    import exe_pkg::*;
(
    input  logic [3:0]  ealuc,
    input  logic        ealuimm,
    input  logic [31:0] eqa,
    input  logic [31:0] eqb,
    input  logic [31:0] eimm32,
    output logic [31:0] r
);

    logic [31:0] opb;
    logic [4:0]  sa;

    assign opb = ealuimm ? eimm32 : eqb;
    // Shift amount comes from the immediate field regardless of ealuimm.
    assign sa  = eimm32[10:6];

    always_comb begin
        r = '0;
        case (ealuc)
            ALUC_ADD: r = eqa + opb;
            ALUC_SUB: r = eqa - opb;
            ALUC_AND: r = eqa & opb;
            ALUC_OR:  r = eqa | opb;
            ALUC_XOR: r = eqa ^ opb;
            ALUC_NOR: r = ~(eqa | opb);
            ALUC_SLT: r = {31'd0, $signed(eqa) < $signed(opb)};
            ALUC_SLL: r = eqb << sa;
            ALUC_SRL: r = eqb >> sa;
            ALUC_SRA: r = $unsigned($signed(eqb) >>> sa);
            ALUC_LUI: r = {opb[15:0], 16'h0000};
            default:  r = '0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// EXE pipeline stage: ALU plus EXE/MEM register. Define EXE_MUL_EN to build
// the 32-step shift-add multiplier (ex_busy stall); otherwise MUL yields 0.
module exe_stage
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic        ealuimm,
    input  logic [3:0]  ealuc,
    input  logic [4:0]  edestReg,
    input  logic [31:0] eqa,
    input  logic [31:0] eqb,
    input  logic [31:0] eimm32,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    output logic [4:0]  mdestReg,
    output logic [31:0] mr,
    output logic [31:0] mqb,
    output logic        ex_busy
);

    logic [31:0] alu_r;

    exe_alu u_alu (
        .ealuc   (ealuc),
        .ealuimm (ealuimm),
        .eqa     (eqa),
        .eqb     (eqb),
        .eimm32  (eimm32),
        .r       (alu_r)
    );

`ifdef EXE_MUL_EN
    mul_state_t  state;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [4:0]  cnt;
    logic [31:0] mul_b;

    assign mul_b   = ealuimm ? eimm32 : eqb;
    assign ex_busy = ((state == MS_IDLE) && (ealuc == ALUC_MUL)) || (state == MS_RUN);

    // Normal load is the default; IDLE-start and RUN override it with a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MS_IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            mwreg    <= 1'b0;
            mm2reg   <= 1'b0;
            mwmem    <= 1'b0;
            mdestReg <= '0;
            mr       <= '0;
            mqb      <= '0;
        end else begin
            mwreg    <= ewreg;
            mm2reg   <= em2reg;
            mwmem    <= ewmem;
            mdestReg <= edestReg;
            mr       <= alu_r;
            mqb      <= eqb;
            case (state)
                MS_IDLE: begin
                    if (ealuc == ALUC_MUL) begin
                        mcand    <= eqa;
                        mplier   <= mul_b;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= MS_RUN;
                        mwreg    <= 1'b0;
                        mm2reg   <= 1'b0;
                        mwmem    <= 1'b0;
                        mdestReg <= '0;
                        mr       <= '0;
                        mqb      <= '0;
                    end
                end
                MS_RUN: begin
                    acc      <= acc + (mplier[0] ? mcand : 32'd0);
                    mcand    <= mcand << 1;
                    mplier   <= mplier >> 1;
                    cnt      <= cnt + 5'd1;
                    mwreg    <= 1'b0;
                    mm2reg   <= 1'b0;
                    mwmem    <= 1'b0;
                    mdestReg <= '0;
                    mr       <= '0;
                    mqb      <= '0;
                    if (cnt == 5'd31) begin
                        state <= MS_DONE;
                    end
                end
                MS_DONE: begin
                    mr    <= acc;
                    state <= MS_IDLE;
                end
                default: state <= MS_IDLE;
            endcase
        end
    end
`else
    assign ex_busy = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mwreg    <= 1'b0;
            mm2reg   <= 1'b0;
            mwmem    <= 1'b0;
            mdestReg <= '0;
            mr       <= '0;
            mqb      <= '0;
        end else begin
            mwreg    <= ewreg;
            mm2reg   <= em2reg;
            mwmem    <= ewmem;
            mdestReg <= edestReg;
            mr       <= alu_r;
            mqb      <= eqb;
        end
    end
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage; multiplier sequences run when EXE_MUL_EN is defined.
module tb_exe_stage;
    import exe_pkg::*;

    logic        clk;
    logic        rst;
    logic        ewreg, em2reg, ewmem, ealuimm;
    logic [3:0]  ealuc;
    logic [4:0]  edestReg;
    logic [31:0] eqa, eqb, eimm32;
    logic        mwreg, mm2reg, mwmem;
    logic [4:0]  mdestReg;
    logic [31:0] mr, mqb;
    logic        ex_busy;

    typedef struct {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  dest;
        logic [31:0] r;
        logic [31:0] qb;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    exe_stage dut (
        .clk      (clk),
        .rst      (rst),
        .ewreg    (ewreg),
        .em2reg   (em2reg),
        .ewmem    (ewmem),
        .ealuimm  (ealuimm),
        .ealuc    (ealuc),
        .edestReg (edestReg),
        .eqa      (eqa),
        .eqb      (eqb),
        .eimm32   (eimm32),
        .mwreg    (mwreg),
        .mm2reg   (mm2reg),
        .mwmem    (mwmem),
        .mdestReg (mdestReg),
        .mr       (mr),
        .mqb      (mqb),
        .ex_busy  (ex_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] qb, input logic [31:0] imm,
                                          input logic aluimm);
        logic [31:0] b;
        logic [63:0] ext;
        logic [4:0]  sa;
        b  = aluimm ? imm : qb;
        sa = imm[10:6];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + ~b + 32'd1;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~a & ~b;
            4'd6:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            4'd7:  return qb << sa;
            4'd8:  return qb >> sa;
            4'd9: begin
                ext = {{32{qb[31]}}, qb} >> sa;
                return ext[31:0];
            end
            4'd10: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic w, input logic m2, input logic wm, input logic ai,
                         input logic [3:0] op, input logic [4:0] d, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        ewreg = w; em2reg = m2; ewmem = wm; ealuimm = ai;
        ealuc = op; edestReg = d; eqa = a; eqb = b; eimm32 = imm;
    endtask

    task automatic push_exp(input logic [31:0] r);
        exp_t e;
        e.wreg = ewreg; e.m2reg = em2reg; e.wmem = ewmem;
        e.dest = edestReg; e.r = r; e.qb = eqb;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_mr"},    mr,              e.r);
            check({tag, "_mwreg"}, {31'd0, mwreg},  {31'd0, e.wreg});
            check({tag, "_mm2r"},  {31'd0, mm2reg}, {31'd0, e.m2reg});
            check({tag, "_mwmem"}, {31'd0, mwmem},  {31'd0, e.wmem});
            check({tag, "_mdest"}, {27'd0, mdestReg}, {27'd0, e.dest});
            check({tag, "_mqb"},   mqb,             e.qb);
        end
    endtask

    task automatic op1(input string tag, input logic w, input logic m2, input logic wm,
                       input logic ai, input logic [3:0] op, input logic [4:0] d,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        @(negedge clk);
        drive(w, m2, wm, ai, op, d, a, b, imm);
        push_exp(model(op, a, b, imm, ai));
        @(negedge clk);
        pop_cmp(tag);
    endtask

`ifdef EXE_MUL_EN
    // Caller must be at a negedge; inputs are held until the result appears.
    task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] d);
        int unsigned busy_cnt;
        int unsigned bubble_bad;
        int unsigned guard;
        drive(1'b1, 1'b0, 1'b0, 1'b0, ALUC_MUL, d, a, b, 32'd0);
        #1;
        check({tag, "_busy0"}, {31'd0, ex_busy}, 32'd1);
        busy_cnt = 1; bubble_bad = 0; guard = 0;
        while (guard < 40) begin
            @(negedge clk);
            guard++;
            if (!ex_busy) break;
            busy_cnt++;
            if (mwreg || mm2reg || mwmem || mdestReg != 5'd0 || mr != 32'd0 || mqb != 32'd0)
                bubble_bad++;
        end
        check({tag, "_busycnt"}, busy_cnt, 32'd33);
        check({tag, "_bubble"}, bubble_bad, 32'd0);
        push_exp(a * b);
        @(negedge clk);
        pop_cmp(tag);
        drive(1'b0, 1'b0, 1'b0, 1'b0, ALUC_ADD, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask
`endif

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, ALUC_ADD, 5'd0, 32'd0, 32'd0, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mr", mr, 32'd0);
        check("rst_ctl", {29'd0, mwreg, mm2reg, mwmem}, 32'd0);
        check("rst_busy", {31'd0, ex_busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        op1("add",  1, 0, 0, 1, ALUC_ADD, 5'd3, 32'd5, 32'd0, 32'd7);
        // Asynchronous reset with a live result in the M register.
        #2 rst = 1'b1;
        #1;
        check("arst_mr", mr, 32'd0);
        check("arst_ctl", {24'd0, mdestReg, mwreg, mm2reg, mwmem}, 32'd0);
        check("arst_busy", {31'd0, ex_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        op1("sub",  1, 0, 0, 0, ALUC_SUB, 5'd4, 32'd0, 32'd1, 32'd0);
        op1("slt",  1, 0, 0, 0, ALUC_SLT, 5'd5, 32'hFFFFFFFF, 32'd1, 32'd0);
        op1("sltu", 1, 0, 0, 0, ALUC_SLT, 5'd5, 32'd1, 32'hFFFFFFFF, 32'd0);
        op1("sra",  1, 0, 0, 0, ALUC_SRA, 5'd6, 32'd0, 32'h80000000, 32'h00000100);
        op1("lui",  1, 0, 0, 1, ALUC_LUI, 5'd7, 32'd0, 32'd0, 32'h00001234);
        op1("and",  0, 1, 0, 0, ALUC_AND, 5'd8, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0);
        op1("nor",  1, 0, 1, 0, ALUC_NOR, 5'd9, 32'h0000_00F0, 32'h0F00_000F, 32'd0);
        op1("sll",  1, 0, 0, 1, ALUC_SLL, 5'd10, 32'd0, 32'h0000_0003, 32'h0000_07C0);
        op1("srl",  1, 0, 0, 0, ALUC_SRL, 5'd11, 32'd0, 32'h8000_0000, 32'h0000_07C0);
        op1("op15", 1, 1, 1, 0, 4'd15,    5'd12, 32'd9, 32'd9, 32'd0);

        for (int i = 0; i < 24; i++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
`ifdef EXE_MUL_EN
            if (rop == ALUC_MUL) rop = ALUC_XOR;
`endif
            op1("rnd", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rop,
                5'($urandom), $urandom, $urandom, $urandom);
        end

`ifdef EXE_MUL_EN
        @(negedge clk);
        mul_run("mul", 32'd1234, 32'd5678, 5'd13);
        @(negedge clk);
        mul_run("mulff", 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14);

        // Reset during RUN, then the held MUL restarts the whole sequence.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, ALUC_MUL, 5'd15, 32'd77, 32'd1000, 32'd0);
        repeat (11) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mrst_mr", mr, 32'd0);
        check("mrst_ctl", {24'd0, mdestReg, mwreg, mm2reg, mwmem}, 32'd0);
        check("mrst_busy", {31'd0, ex_busy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        mul_run("mulrst", 32'd77, 32'd1000, 5'd15);

        op1("post", 1, 0, 0, 0, ALUC_OR, 5'd16, 32'h00FF_0000, 32'h0000_00FF, 32'd0);
`else
        op1("mul0", 1, 0, 0, 0, ALUC_MUL, 5'd13, 32'd1234, 32'd5678, 32'd0);
        check("mul0_busy", {31'd0, ex_busy}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
